// File: rtl/seg_scan_decoder_if.sv
// Bus between a seven-segment display scanner and the decoder that reads it back:
// the raw segment/anode pins plus the decoded per-digit view.
interface seg_scan_decoder_if #(
  parameter int NUM_DIGITS = 4
);
  logic [6:0]              seg_in;
  logic [NUM_DIGITS-1:0]   an_in;
  logic [4*NUM_DIGITS-1:0] digit_val;
  logic [NUM_DIGITS-1:0]   digit_ok;
  logic                    upd;
  logic                    err;

  modport master (
    output seg_in, an_in,
    input  digit_val, digit_ok, upd, err
  );

  modport slave (
    input  seg_in, an_in,
    output digit_val, digit_ok, upd, err
  );
endinterface

// File: rtl/seg_scan_decoder.sv
// Reads back a multiplexed seven-segment display: synchronizes the pins, waits for a
// stable window, then decodes the pattern into a per-digit register file.
module seg_scan_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  seg_scan_decoder_if.slave  bus
);
  localparam int SW = NUM_DIGITS + 7;
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_SAT  = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  // {valid, nibble}; exact match on active-low a..g only
  function automatic logic [4:0] seg_decode(input logic [6:0] seg);
    case (seg)
      7'b0000001: seg_decode = {1'b1, 4'h0};
      7'b1001111: seg_decode = {1'b1, 4'h1};
      7'b0010010: seg_decode = {1'b1, 4'h2};
      7'b0000110: seg_decode = {1'b1, 4'h3};
      7'b1001100: seg_decode = {1'b1, 4'h4};
      7'b0100100: seg_decode = {1'b1, 4'h5};
      7'b0100000: seg_decode = {1'b1, 4'h6};
      7'b0001111: seg_decode = {1'b1, 4'h7};
      7'b0000000: seg_decode = {1'b1, 4'h8};
      7'b0000100: seg_decode = {1'b1, 4'h9};
      7'b0000010: seg_decode = {1'b1, 4'hA};
      7'b1100000: seg_decode = {1'b1, 4'hB};
      7'b0110001: seg_decode = {1'b1, 4'hC};
      7'b1000010: seg_decode = {1'b1, 4'hD};
      7'b0010000: seg_decode = {1'b1, 4'hE};
      7'b0111000: seg_decode = {1'b1, 4'hF};
      default:    seg_decode = {1'b0, 4'h0};
    endcase
  endfunction

  function automatic logic [IW-1:0] low_index(input logic [NUM_DIGITS-1:0] an);
    low_index = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!an[i]) low_index = IW'(i);
    end
  endfunction

  logic [SW-1:0]           r_sync1, r_sync2, r_last;
  logic [CW-1:0]           r_cnt;
  logic                    r_committed;
  logic [4*NUM_DIGITS-1:0] r_digit_val;
  logic [NUM_DIGITS-1:0]   r_digit_ok;
  logic                    r_upd, r_err;

  logic [NUM_DIGITS-1:0]   w_an;
  logic [6:0]              w_seg;
  logic [4:0]              w_dec;
  logic [IW-1:0]           w_idx;
  logic                    w_same, w_commit;
  logic [4*NUM_DIGITS-1:0] w_val_next;
  logic [NUM_DIGITS-1:0]   w_ok_next;
  logic                    w_upd_next, w_err_next;

  assign w_an     = r_sync2[SW-1:7];
  assign w_seg    = r_sync2[6:0];
  assign w_dec    = seg_decode(w_seg);
  assign w_idx    = low_index(w_an);
  assign w_same   = (r_sync2 == r_last);
  // The edge that first sees a new sample counts as 1, so the last edge of the window sees STABLE_CYCLES-1
  assign w_commit = w_same && !r_committed && (r_cnt == CNT_LAST);

  // Commit decision: what the register file and pulses become on this edge
  always_comb begin
    w_val_next = r_digit_val;
    w_ok_next  = r_digit_ok;
    w_upd_next = 1'b0;
    w_err_next = 1'b0;
    if (!w_commit || (&w_an)) begin
      w_upd_next = 1'b0;
    end else if (!$onehot(~w_an)) begin
      w_err_next = 1'b1;
    end else if (w_dec[4]) begin
      w_upd_next = !r_digit_ok[w_idx] || (r_digit_val[{w_idx, 2'b00} +: 4] != w_dec[3:0]);
      w_val_next[{w_idx, 2'b00} +: 4] = w_dec[3:0];
      w_ok_next[w_idx] = 1'b1;
    end else if (w_seg == 7'b1111111) begin
      w_upd_next = r_digit_ok[w_idx];
      w_ok_next[w_idx] = 1'b0;
    end else begin
      w_ok_next[w_idx] = 1'b0;
      w_err_next = 1'b1;
    end
  end

  // Synchronizer, stability window and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1     <= '1;
      r_sync2     <= '1;
      r_last      <= '1;
      r_cnt       <= '0;
      r_committed <= 1'b0;
      r_digit_val <= '0;
      r_digit_ok  <= '0;
      r_upd       <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_sync1 <= {bus.an_in, bus.seg_in};
      r_sync2 <= r_sync1;
      r_last  <= r_sync2;
      if (!w_same) begin
        r_cnt       <= CW'(1);
        r_committed <= 1'b0;
      end else begin
        if (r_cnt != CNT_SAT) r_cnt <= r_cnt + CW'(1);
        if (w_commit) r_committed <= 1'b1;
      end
      r_digit_val <= w_val_next;
      r_digit_ok  <= w_ok_next;
      r_upd       <= w_upd_next;
      r_err       <= w_err_next;
    end
  end

  assign bus.digit_val = r_digit_val;
  assign bus.digit_ok  = r_digit_ok;
  assign bus.upd       = r_upd;
  assign bus.err       = r_err;
endmodule

// File: tb/tb_seg_scan_decoder.sv
// Self-checking bench for seg_scan_decoder: directed scenarios plus random scanning,
// all compared against a pin-history reference model.
module tb_seg_scan_decoder;
  localparam int ND = 4;
  localparam int S  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg_scan_decoder_if #(.NUM_DIGITS(ND)) bus ();
  seg_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  logic [6:0] lut [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                           7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                           7'b0000000, 7'b0000100, 7'b0000010, 7'b1100000,
                           7'b0110001, 7'b1000010, 7'b0010000, 7'b0111000};

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the sample seen on an edge is the pin value from two edges
  // earlier (all ones shortly after reset); a commit is the S-th identical sample in a row.
  logic [ND+6:0]   ph [$];
  logic [ND+6:0]   sh [$];
  logic [4*ND-1:0] m_val;
  logic [ND-1:0]   m_ok;
  logic            m_upd, m_err;

  always @(posedge clk) begin : model
    logic [ND+6:0] s;
    logic [ND-1:0] a;
    logic [6:0]    g;
    int n, zeros, idx, found;
    bit commit;
    m_upd = 1'b0;
    m_err = 1'b0;
    if (!rst_n) begin
      ph.delete();
      sh.delete();
      m_val = '0;
      m_ok  = '0;
    end else begin
      ph.push_back({bus.an_in, bus.seg_in});
      if (ph.size() <= 2) s = '1;
      else s = ph[ph.size()-3];
      sh.push_back(s);
      n = sh.size();
      commit = (n >= S);
      if (commit) for (int i = 1; i < S; i++) if (sh[n-1-i] != s) commit = 0;
      if (commit && n > S && sh[n-1-S] == s) commit = 0;
      if (commit) begin
        a = s[ND+6:7];
        g = s[6:0];
        zeros = 0;
        idx = 0;
        for (int i = 0; i < ND; i++) if (!a[i]) begin zeros++; idx = i; end
        if (zeros > 1) m_err = 1'b1;
        else if (zeros == 1) begin
          found = -1;
          for (int k = 0; k < 16; k++) if (lut[k] == g) found = k;
          if (found >= 0) begin
            if (!m_ok[idx] || m_val[idx*4 +: 4] != 4'(found)) m_upd = 1'b1;
            m_val[idx*4 +: 4] = 4'(found);
            m_ok[idx] = 1'b1;
          end else if (g == 7'b1111111) begin
            if (m_ok[idx]) m_upd = 1'b1;
            m_ok[idx] = 1'b0;
          end else begin
            m_ok[idx] = 1'b0;
            m_err = 1'b1;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [ND-1:0] an, input logic [6:0] seg);
    bus.an_in  = an;
    bus.seg_in = seg;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int c = 0; c < 2; c++) begin
      drive(4'($urandom), 7'($urandom));
      tick();
      n_checks++;
      if ({bus.digit_val, bus.digit_ok, bus.upd, bus.err} !== {16'h0000, 4'b0000, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL reset_hold: got %h/%b/%b/%b want 0000/0000/0/0", bus.digit_val, bus.digit_ok, bus.upd, bus.err);
      end
    end
    drive(4'b1111, 7'b1111111);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      n_checks++;
      if ({bus.digit_val, bus.digit_ok, bus.upd, bus.err} !== {16'h0000, 4'b0000, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL reset_release: got %h/%b/%b/%b want 0000/0000/0/0", bus.digit_val, bus.digit_ok, bus.upd, bus.err);
      end
    end
  endtask

  task automatic test_single_commit();
    int pulses = 0;
    drive(4'b1110, 7'b0010010);
    for (int c = 0; c < 20; c++) begin
      tick();
      pulses += int'(bus.upd);
      n_checks++;
      if (bus.upd !== (c == 5)) begin
        n_fail++;
        $display("FAIL single_latency: cycle %0d upd=%b want %b", c, bus.upd, (c == 5));
      end
      n_checks++;
      if ({bus.digit_val, bus.digit_ok, bus.upd, bus.err} !== {m_val, m_ok, m_upd, m_err}) begin
        n_fail++;
        $display("FAIL single_model: got %h/%b/%b/%b want %h/%b/%b/%b", bus.digit_val, bus.digit_ok, bus.upd, bus.err, m_val, m_ok, m_upd, m_err);
      end
    end
    n_checks++;
    if (bus.digit_val[3:0] !== 4'h2 || bus.digit_ok !== 4'b0001 || pulses != 1) begin
      n_fail++;
      $display("FAIL single_result: got val=%h ok=%b pulses=%0d want 2/0001/1", bus.digit_val[3:0], bus.digit_ok, pulses);
    end
  endtask

  task automatic test_glitch();
    int pulses = 0;
    drive(4'b1101, 7'b0000110);
    for (int c = 0; c < 13; c++) begin
      if (c == 3) drive(4'b1111, 7'b1111111);
      tick();
      pulses += int'(bus.upd);
      n_checks++;
      if ({bus.digit_val, bus.digit_ok, bus.upd, bus.err} !== {m_val, m_ok, m_upd, m_err}) begin
        n_fail++;
        $display("FAIL glitch_model: got %h/%b/%b/%b want %h/%b/%b/%b", bus.digit_val, bus.digit_ok, bus.upd, bus.err, m_val, m_ok, m_upd, m_err);
      end
    end
    n_checks++;
    if (bus.digit_ok[1] !== 1'b0 || pulses != 0) begin
      n_fail++;
      $display("FAIL glitch_reject: got ok1=%b pulses=%0d want 0/0", bus.digit_ok[1], pulses);
    end
  endtask

  task automatic test_full_scan();
    logic [3:0] vals [4] = '{4'h3, 4'hA, 4'hF, 4'h7};
    for (int pass = 0; pass < 2; pass++) begin
      int pulses = 0;
      for (int d = 0; d < 4; d++) begin
        drive(~(4'b0001 << d), lut[vals[d]]);
        for (int c = 0; c < 8; c++) begin
          tick();
          pulses += int'(bus.upd);
          n_checks++;
          if ({bus.digit_val, bus.digit_ok, bus.upd, bus.err} !== {m_val, m_ok, m_upd, m_err}) begin
            n_fail++;
            $display("FAIL scan_model: got %h/%b/%b/%b want %h/%b/%b/%b", bus.digit_val, bus.digit_ok, bus.upd, bus.err, m_val, m_ok, m_upd, m_err);
          end
        end
      end
      n_checks++;
      if (bus.digit_val !== 16'h7FA3 || bus.digit_ok !== 4'b1111 || pulses != (pass == 0 ? 4 : 0)) begin
        n_fail++;
        $display("FAIL scan_result pass %0d: got %h/%b pulses=%0d want 7fa3/1111/%0d", pass, bus.digit_val, bus.digit_ok, pulses, (pass == 0 ? 4 : 0));
      end
    end
  endtask

  task automatic test_illegal();
    logic [ND-1:0] ans [2]  = '{4'b1101, 4'b1100};
    logic [6:0]    segs [2] = '{7'b1111110, 7'b0100100};
    for (int t = 0; t < 2; t++) begin
      int errs = 0;
      int upds = 0;
      drive(ans[t], segs[t]);
      for (int c = 0; c < 8; c++) begin
        tick();
        errs += int'(bus.err);
        upds += int'(bus.upd);
        n_checks++;
        if ({bus.digit_val, bus.digit_ok, bus.upd, bus.err} !== {m_val, m_ok, m_upd, m_err}) begin
          n_fail++;
          $display("FAIL illegal_model: got %h/%b/%b/%b want %h/%b/%b/%b", bus.digit_val, bus.digit_ok, bus.upd, bus.err, m_val, m_ok, m_upd, m_err);
        end
      end
      n_checks++;
      if (errs != 1 || upds != 0 || bus.digit_val !== 16'h7FA3 || bus.digit_ok !== 4'b1101) begin
        n_fail++;
        $display("FAIL illegal_%0d: got err=%0d upd=%0d val=%h ok=%b want 1/0/7fa3/1101", t, errs, upds, bus.digit_val, bus.digit_ok);
      end
    end
  endtask

  task automatic test_reset_mid_window();
    drive(4'b1111, 7'b1111111);
    for (int c = 0; c < 8; c++) tick();
    drive(4'b1011, lut[5]);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    n_checks++;
    if (bus.digit_ok !== 4'b0000 || bus.upd !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_clear: got ok=%b upd=%b want 0000/0", bus.digit_ok, bus.upd);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      n_checks++;
      if (bus.upd !== (c == S + 1)) begin
        n_fail++;
        $display("FAIL midrst_latency: edge %0d upd=%b want %b", c + 1, bus.upd, (c == S + 1));
      end
    end
    n_checks++;
    if (bus.digit_val !== 16'h0500 || bus.digit_ok !== 4'b0100) begin
      n_fail++;
      $display("FAIL midrst_result: got %h/%b want 0500/0100", bus.digit_val, bus.digit_ok);
    end
  endtask

  task automatic test_saturation();
    int pulses = 0;
    drive(4'b1110, lut[9]);
    for (int c = 0; c < 40; c++) begin
      tick();
      pulses += int'(bus.upd) + int'(bus.err);
    end
    n_checks++;
    if (pulses != 1 || bus.digit_val[3:0] !== 4'h9) begin
      n_fail++;
      $display("FAIL saturation: got pulses=%0d val=%h want 1/9", pulses, bus.digit_val[3:0]);
    end
  endtask

  task automatic test_random();
    int cyc = 0;
    while (cyc < 400) begin
      int kind = int'($urandom_range(0, 9));
      int hold = int'($urandom_range(1, 8));
      logic [ND-1:0] one = ~(4'b0001 << $urandom_range(0, ND - 1));
      case (kind)
        0:       drive(4'b1111, 7'($urandom));
        1:       drive(4'($urandom), lut[$urandom_range(0, 15)]);
        2:       drive(one, 7'($urandom));
        3:       drive(one, 7'b1111111);
        default: drive(one, lut[$urandom_range(0, 15)]);
      endcase
      for (int c = 0; c < hold; c++) begin
        tick();
        cyc++;
        n_checks++;
        if ({bus.digit_val, bus.digit_ok, bus.upd, bus.err} !== {m_val, m_ok, m_upd, m_err}) begin
          n_fail++;
          $display("FAIL random_model: got %h/%b/%b/%b want %h/%b/%b/%b", bus.digit_val, bus.digit_ok, bus.upd, bus.err, m_val, m_ok, m_upd, m_err);
        end
        n_checks++;
        if (bus.upd && bus.err) begin
          n_fail++;
          $display("FAIL random_exclusive: got upd=1 err=1 want not both");
        end
      end
    end
  endtask

  initial begin
    drive(4'b1111, 7'b1111111);
    @(negedge clk);
    test_reset();
    test_single_commit();
    test_glitch();
    test_full_scan();
    test_illegal();
    test_reset_mid_window();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
